mem_line_responder: RTL and testbench

- Memory-side responder for the processor's cache-line request interface: accepts one line read (fill) or line write (writeback) at a time.
- Models fixed-latency main memory and returns a single response per request.
- Sits below the fetch/memory-stage caches: the caches are the initiator, this block is the responder.
- Lines are 128 bits (four 32-bit lanes, lane 0 at bits [31:0]); addresses are 36-bit byte addresses.

---
 rtl/mem_line_responder.sv | 124 ++++++++++++
 tb/tb_mem_line_responder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// Fixed-latency line-memory responder: one line read or write in flight, one response each.
// Optional MEM_RESP_ERR_EN adds resp_err for addresses whose bits above the index are nonzero.
module mem_line_responder #(
  parameter int ADDR_W  = 36,
  parameter int LINE_W  = 128,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [LINE_W-1:0] resp_rdata,
`ifdef MEM_RESP_ERR_EN
  output logic              resp_err,
`endif
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic                we_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                oor_q;
  logic                complete;
  logic                mem_we;
  logic [LINE_W-1:0]   mem [DEPTH];

`ifdef MEM_RESP_ERR_EN
  logic req_oor;
  logic unused_addr_bits;
  assign req_oor          = |req_addr[ADDR_W-1:4+IDX_W];
  assign unused_addr_bits = ^req_addr[3:0];
`else
  logic req_oor;
  logic unused_addr_bits;
  assign req_oor          = 1'b0;
  assign unused_addr_bits = ^{req_addr[3:0], req_addr[ADDR_W-1:4+IDX_W]};
`endif

  // NOTE: req_ready is decoded from state and gated by rst so it is 0 during reset
  // and 1 as soon as reset deasserts, with no extra cycle of delay.
  assign req_ready = (state == IDLE) && !rst;

  assign complete = (state == WAIT) && (cnt == 8'd0);
  assign mem_we   = complete && we_q && !oor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rdata <= '0;
      busy       <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            idx_q   <= req_addr[4 +: IDX_W];
            wdata_q <= req_wdata;
            oor_q   <= req_oor;
            cnt     <= 8'(LATENCY - 1);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            resp_valid <= 1'b1;
            resp_we    <= we_q;
            resp_rdata <= (we_q || oor_q) ? '0 : mem[idx_q];
`ifdef MEM_RESP_ERR_EN
            resp_err   <= oor_q;
`endif
            state      <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          // Response fields stay frozen until the initiator takes them.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_rdata <= '0;
            busy       <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            resp_err   <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the backing array has no reset; its contents survive rst by design and
  // a reset before the completion edge simply never raises mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: LATENCY=4 main instance plus a LATENCY=1 instance.
module tb_mem_line_responder;

  localparam logic [127:0] LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] LINE_1 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] LINE_2 = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] LINE_J = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
  localparam logic [127:0] LINE_5 = 128'h55555555_AAAAAAAA_12345678_87654321;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [35:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         req_ready, resp_valid, resp_we, busy;
  logic [127:0] resp_rdata;

  logic         l_req_valid = 1'b0, l_req_we = 1'b0, l_resp_ready = 1'b0;
  logic [35:0]  l_req_addr = '0;
  logic [127:0] l_req_wdata = '0;
  logic         l_req_ready, l_resp_valid, l_resp_we, l_busy;
  logic [127:0] l_resp_rdata;

`ifdef MEM_RESP_ERR_EN
  logic resp_err, l_resp_err;
`endif
  logic last_err = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_line_responder #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rdata(resp_rdata),
`ifdef MEM_RESP_ERR_EN
    .resp_err(resp_err),
`endif
    .busy(busy)
  );

  mem_line_responder #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(l_req_valid), .req_ready(l_req_ready), .req_we(l_req_we),
    .req_addr(l_req_addr), .req_wdata(l_req_wdata),
    .resp_valid(l_resp_valid), .resp_ready(l_resp_ready), .resp_we(l_resp_we),
    .resp_rdata(l_resp_rdata),
`ifdef MEM_RESP_ERR_EN
    .resp_err(l_resp_err),
`endif
    .busy(l_busy)
  );

  // Issue one request on the LATENCY=4 instance and wait for resp_valid; leaves it pending.
  task automatic txn(input logic we, input logic [35:0] addr, input logic [127:0] data,
                     output logic [127:0] rd, output logic rwe, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL txn_ready_timeout: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (resp_valid) break;
    end
    rd  = resp_rdata;
    rwe = resp_we;
`ifdef MEM_RESP_ERR_EN
    last_err = resp_err;
`endif
  endtask

  task automatic finish_resp(input string name);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: valid=%b ready=%b busy=%b expected 0/1/0",
               name, resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_we !== 1'b0 ||
        resp_rdata !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b valid=%b we=%b rdata=%h busy=%b expected all 0",
               req_ready, resp_valid, resp_we, resp_rdata, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || l_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ready=%b l1_ready=%b expected 1", req_ready, l_req_ready);
    end
  endtask

  task automatic test_write_read;
    logic [127:0] rd;
    logic rwe;
    int lat;
    txn(1'b1, 36'h0_0000_0010, LINE_A, rd, rwe, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL write_latency: got %0d expected 4", lat); end
    checks++;
    if (rwe !== 1'b1 || rd !== '0) begin
      errors++;
      $display("FAIL write_resp: we=%b rdata=%h expected 1/0", rwe, rd);
    end
    finish_resp("write");
    txn(1'b0, 36'h0_0000_0010, '0, rd, rwe, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d expected 4", lat); end
    checks++;
    if (rwe !== 1'b0 || rd !== LINE_A) begin
      errors++;
      $display("FAIL read_data: we=%b rdata=%h expected 0/%h", rwe, rd, LINE_A);
    end
    checks++;
    if (rd[31:0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL read_lane0: got %h expected cafef00d", rd[31:0]);
    end
    finish_resp("read");
    txn(1'b0, 36'h0_0000_001C, '0, rd, rwe, lat);
    checks++;
    if (rd !== LINE_A) begin
      errors++;
      $display("FAIL read_offset: rdata=%h expected %h", rd, LINE_A);
    end
    finish_resp("offset");
  endtask

  task automatic test_backpressure;
    logic [127:0] rd;
    logic rwe;
    int lat;
    int bad;
    txn(1'b0, 36'h0_0000_0010, '0, rd, rwe, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 36'h0_0000_0010; req_wdata = LINE_J;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== LINE_A || resp_we !== 1'b0 ||
          req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b rdata=%h ready=%b busy=%b expected 1/%h/0/1",
                 i, resp_valid, resp_rdata, req_ready, busy, LINE_A);
      end
    end
    req_valid = 1'b0;
    finish_resp("stall");
    txn(1'b0, 36'h0_0000_0010, '0, rd, rwe, lat);
    checks++;
    if (rd !== LINE_A) begin
      errors++;
      $display("FAIL stall_ignored_req: rdata=%h expected %h", rd, LINE_A);
    end
    finish_resp("stall_reread");
  endtask

  task automatic test_reset_mid_write;
    logic [127:0] rd;
    logic rwe;
    int lat;
    txn(1'b1, 36'h0_0000_0020, LINE_2, rd, rwe, lat);
    finish_resp("pre_write");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 36'h0_0000_0020; req_wdata = LINE_1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_we !== 1'b0 ||
        resp_rdata !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%b valid=%b we=%b rdata=%h busy=%b expected all 0",
               req_ready, resp_valid, resp_we, resp_rdata, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: ready=%b busy=%b expected 1/0", req_ready, busy);
    end
    repeat (6) @(posedge clk);
    txn(1'b0, 36'h0_0000_0020, '0, rd, rwe, lat);
    checks++;
    if (rd !== LINE_2) begin
      errors++;
      $display("FAIL midrst_not_committed: rdata=%h expected %h", rd, LINE_2);
    end
    finish_resp("midrst_read");
  endtask

  task automatic l1_req(input logic we, input logic [35:0] addr, input logic [127:0] data,
                        input logic [127:0] exp_rd, input string name);
    l_resp_ready = 1'b1;
    @(negedge clk);
    l_req_valid = 1'b1; l_req_we = we; l_req_addr = addr; l_req_wdata = data;
    @(posedge clk);
    #1 l_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (l_resp_valid !== 1'b0 || l_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept_cycle: valid=%b ready=%b expected 0/0", name, l_resp_valid, l_req_ready);
    end
    @(negedge clk);
    checks++;
    if (l_resp_valid !== 1'b1 || l_resp_we !== we || l_resp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL %s_lat1_resp: valid=%b we=%b rdata=%h expected 1/%b/%h",
               name, l_resp_valid, l_resp_we, l_resp_rdata, we, exp_rd);
    end
    @(negedge clk);
    checks++;
    if (l_resp_valid !== 1'b0 || l_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_lat1_hs: valid=%b ready=%b expected 0/1", name, l_resp_valid, l_req_ready);
    end
  endtask

  task automatic test_latency1;
    int n_resp;
    int n_ready;
    l1_req(1'b1, 36'h0_0000_0050, LINE_5, '0, "l1_write");
    l1_req(1'b0, 36'h0_0000_0050, '0, LINE_5, "l1_read");
    n_resp = 0;
    n_ready = 0;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 36'h0_0000_0050;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (l_resp_valid) n_resp++;
      if (l_req_ready) n_ready++;
    end
    l_req_valid = 1'b0;
    checks++;
    if (n_resp !== 4 || n_ready !== 4) begin
      errors++;
      $display("FAIL l1_throughput: resp=%0d ready=%0d in 12 cycles expected 4/4", n_resp, n_ready);
    end
    @(negedge clk);
    l_resp_ready = 1'b0;
  endtask

`ifdef MEM_RESP_ERR_EN
  task automatic test_err;
    logic [127:0] rd;
    logic rwe;
    int lat;
    txn(1'b1, 36'h0_0000_0000, LINE_5, rd, rwe, lat);
    finish_resp("err_seed");
    txn(1'b0, 36'h1_0000_4000, '0, rd, rwe, lat);
    checks++;
    if (last_err !== 1'b1 || rd !== '0) begin
      errors++;
      $display("FAIL err_oor_read: err=%b rdata=%h expected 1/0", last_err, rd);
    end
    finish_resp("err_read");
    txn(1'b1, 36'h1_0000_4000, LINE_J, rd, rwe, lat);
    checks++;
    if (last_err !== 1'b1) begin
      errors++;
      $display("FAIL err_oor_write: err=%b expected 1", last_err);
    end
    finish_resp("err_write");
    txn(1'b0, 36'h0_0000_0000, '0, rd, rwe, lat);
    checks++;
    if (last_err !== 1'b0 || rd !== LINE_5) begin
      errors++;
      $display("FAIL err_inrange: err=%b rdata=%h expected 0/%h", last_err, rd, LINE_5);
    end
    finish_resp("err_inrange");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_reset_mid_write();
    test_latency1();
`ifdef MEM_RESP_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
